// File: rtl/clint_timer.sv
// Core-local interruptor: mtime, mtimecmp and msip behind a valid/ready register port.
// Define CLINT_TIMER_HALT_EN to add a timer_halt input that freezes the prescaler and mtime.
module clint_timer #(
    parameter int unsigned PRESCALE     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef CLINT_TIMER_HALT_EN
    input  logic        timer_halt,
`endif
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mtip,
    output logic        msip,
    output logic [63:0] mtime_o
);

    localparam logic [15:0] ADDR_MSIP     = 16'h0000;
    localparam logic [15:0] ADDR_MTIMECMP = 16'h4000;
    localparam logic [15:0] ADDR_MTIME    = 16'hBFF8;
    localparam logic [15:0] PRESCALE_MAX  = 16'(PRESCALE - 1);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip_reg;
    logic [15:0] prescaler;

    logic        halt;
    logic        tick;
    logic        accept;
    logic        hit_msip;
    logic        hit_mtimecmp;
    logic        hit_mtime;
    logic        addr_ok;
    logic [63:0] bit_mask;
    logic [63:0] rd_data;

`ifdef CLINT_TIMER_HALT_EN
    assign halt = timer_halt;
`else
    assign halt = 1'b0;
`endif

    assign tick         = !halt && (prescaler == PRESCALE_MAX);
    assign req_ready    = !resp_valid || resp_ready;
    assign accept       = req_valid && req_ready;
    assign hit_msip     = (req_addr == ADDR_MSIP);
    assign hit_mtimecmp = (req_addr == ADDR_MTIMECMP);
    assign hit_mtime    = (req_addr == ADDR_MTIME);
    assign addr_ok      = hit_msip || hit_mtimecmp || hit_mtime;

    assign msip    = msip_reg;
    assign mtime_o = mtime;

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8] = {8{req_wmask[i]}};
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit_msip)     rd_data = {63'd0, msip_reg};
        if (hit_mtimecmp) rd_data = mtimecmp;
        if (hit_mtime)    rd_data = mtime;
    end

    // A bus write to mtime wins over a coincident increment; the prescaler ignores writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            mtime     <= '0;
        end else begin
            if (!halt) begin
                prescaler <= tick ? 16'd0 : prescaler + 16'd1;
            end
            if (accept && req_wen && hit_mtime) begin
                mtime <= (mtime & ~bit_mask) | (req_wdata & bit_mask);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtimecmp <= MTIMECMP_RST;
            msip_reg <= 1'b0;
        end else if (accept && req_wen) begin
            if (hit_mtimecmp) begin
                mtimecmp <= (mtimecmp & ~bit_mask) | (req_wdata & bit_mask);
            end
            if (hit_msip && req_wmask[0]) begin
                msip_reg <= req_wdata[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_err   <= !addr_ok;
            resp_rdata <= (req_wen || !addr_ok) ? 64'd0 : rd_data;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtip <= 1'b0;
        end else begin
            mtip <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: a PRESCALE=1 instance on the bus plus an idle PRESCALE=4 instance.
// With CLINT_TIMER_HALT_EN defined, timer_halt on the PRESCALE=4 instance is exercised as well.
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [15:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mtip;
    logic        msip;
    logic [63:0] mtime_o;

    logic        req_ready4;
    logic        resp_valid4;
    logic [63:0] resp_rdata4;
    logic        resp_err4;
    logic        mtip4;
    logic        msip4;
    logic [63:0] mtime4;

`ifdef CLINT_TIMER_HALT_EN
    logic        timer_halt4 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clint_timer #(.PRESCALE(1)) dut (
        .clk(clk), .rst(rst),
`ifdef CLINT_TIMER_HALT_EN
        .timer_halt(1'b0),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mtip(mtip), .msip(msip), .mtime_o(mtime_o)
    );

    clint_timer #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst),
`ifdef CLINT_TIMER_HALT_EN
        .timer_halt(timer_halt4),
`endif
        .req_valid(1'b0), .req_ready(req_ready4), .req_wen(1'b0),
        .req_addr(16'h0), .req_wdata(64'h0), .req_wmask(8'h0),
        .resp_valid(resp_valid4), .resp_ready(1'b1), .resp_rdata(resp_rdata4),
        .resp_err(resp_err4), .mtip(mtip4), .msip(msip4), .mtime_o(mtime4)
    );

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus request driven at the falling edge; outputs are sampled 1 ns after the accepting edge.
    task automatic apply_stimulus(input logic wen, input logic [15:0] addr,
                                  input logic [63:0] wdata, input logic [7:0] wmask);
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        #1;
        check_output("req_ready_before_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic [63:0] rdata, input logic err);
        check_output({tag, "_valid"}, resp_valid, 1);
        check_output({tag, "_rdata"}, resp_rdata, rdata);
        check_output({tag, "_err"}, resp_err, err);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic found;

        step(3);
        check_output("in_reset_mtime", mtime_o, 0);
        check_output("in_reset_resp_valid", resp_valid, 0);
        check_output("in_reset_mtip", mtip, 0);
        @(negedge clk);
        rst = 1'b1;

        step(10);
        check_output("idle10_mtime", mtime_o, 64'd10);
        check_output("idle10_mtip", mtip, 0);
        check_output("idle10_msip", msip, 0);
        check_output("idle10_resp_valid", resp_valid, 0);
        check_output("idle10_req_ready", req_ready, 1);
        check_output("idle10_mtime_pre4", mtime4, 64'd2);

        step(6);
        check_output("idle16_mtime_pre4", mtime4, 64'd4);
        check_output("idle16_mtime", mtime_o, 64'd16);

`ifdef CLINT_TIMER_HALT_EN
        @(negedge clk);
        timer_halt4 = 1'b1;
        step(8);
        check_output("halt8_mtime_pre4", mtime4, 64'd4);
        @(negedge clk);
        timer_halt4 = 1'b0;
        step(4);
        check_output("unhalt4_mtime_pre4", mtime4, 64'd5);
`endif

        // mtip rises one cycle after mtime reaches mtimecmp
        apply_stimulus(1'b1, 16'h4000, 64'h20, 8'hFF);
        check_resp("wr_cmp20", 64'd0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1);
            if (mtime_o == 64'h20) found = 1'b1;
        end
        check_output("mtime_reaches_20", found, 1);
        check_output("mtip_at_mtime_20", mtip, 0);
        step(1);
        check_output("mtip_after_mtime_20", mtip, 1);

        apply_stimulus(1'b1, 16'h4000, 64'h100, 8'hFF);
        check_output("mtip_on_cmp100_edge", mtip, 1);
        step(1);
        check_output("mtip_after_cmp100", mtip, 0);

        // wrap: mtimecmp all-ones, mtime walks FE -> FF -> 0 -> 1
        apply_stimulus(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        apply_stimulus(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        check_output("wrap_mtime_fe", mtime_o, 64'hFFFF_FFFF_FFFF_FFFE);
        check_output("wrap_mtip_fe", mtip, 0);
        step(1);
        check_output("wrap_mtime_ff", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("wrap_mtip_ff", mtip, 0);
        step(1);
        check_output("wrap_mtime_0", mtime_o, 64'd0);
        check_output("wrap_mtip_0", mtip, 1);
        step(1);
        check_output("wrap_mtime_1", mtime_o, 64'd1);
        check_output("wrap_mtip_1", mtip, 0);

        // back-to-back full write, byte-1 merge, then readback of pre-increment value
        apply_stimulus(1'b1, 16'hBFF8, 64'h1000, 8'hFF);
        apply_stimulus(1'b1, 16'hBFF8, 64'hAAAA_AAAA_AAAA_55AA, 8'h02);
        apply_stimulus(1'b0, 16'hBFF8, 64'h0, 8'h00);
        check_resp("rd_mtime_merged", 64'h5500, 1'b0);
        check_output("mtime_after_merge_read", mtime_o, 64'h5501);

        apply_stimulus(1'b1, 16'h0000, 64'h1, 8'hFF);
        check_resp("wr_msip1", 64'd0, 1'b0);
        check_output("msip_set", msip, 1);
        apply_stimulus(1'b0, 16'h0000, 64'h0, 8'h00);
        check_resp("rd_msip1", 64'h1, 1'b0);
        apply_stimulus(1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFE, 8'h01);
        check_output("msip_clear", msip, 0);
        apply_stimulus(1'b0, 16'h0000, 64'h0, 8'h00);
        check_resp("rd_msip0", 64'h0, 1'b0);

        apply_stimulus(1'b0, 16'h1234, 64'h0, 8'h00);
        check_resp("rd_unmapped", 64'd0, 1'b1);
        apply_stimulus(1'b0, 16'h4004, 64'h0, 8'h00);
        check_resp("rd_misaligned", 64'd0, 1'b1);
        apply_stimulus(1'b1, 16'h4004, 64'h0, 8'hFF);
        check_resp("wr_misaligned", 64'd0, 1'b1);
        apply_stimulus(1'b1, 16'h0001, 64'h1, 8'hFF);
        check_resp("wr_msip_misaligned", 64'd0, 1'b1);
        check_output("msip_after_err_wr", msip, 0);
        apply_stimulus(1'b0, 16'h4000, 64'h0, 8'h00);
        check_resp("rd_cmp_after_err", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // backpressure: response must hold while a second request waits
        step(1);
        check_output("drained_resp_valid", resp_valid, 0);
        resp_ready = 1'b0;
        apply_stimulus(1'b0, 16'h4000, 64'h0, 8'h00);
        check_resp("bp_first", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_output("bp_req_ready_low", req_ready, 0);
            check_resp("bp_hold", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
        check_output("bp_req_ready_release", req_ready, 1);
        step(1);
        req_valid = 1'b0;
        check_resp("bp_second", 64'd0, 1'b1);
        step(1);
        check_output("bp_resp_consumed", resp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
